// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues word requests over req/ack and buffers
// {pc, inst} in a DEPTH-entry FIFO. Define FETCH_BYPASS_EN to forward an ack straight to the core.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e          st_q, st_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [63:0]     target_q, target_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [63:0]     pc_mem_q   [DEPTH];

  logic fifo_valid, ack, fifo_pop, push, bypass;

  // Request and address come only from registers.
  assign imem_req   = (st_q != StIdle);
  assign imem_addr  = fetch_pc_q;
  assign ack        = imem_req & imem_ack;
  assign fifo_valid = (cnt_q != '0);
  assign fifo_pop   = fifo_valid & inst_ready;

`ifdef FETCH_BYPASS_EN
  assign bypass     = !fifo_valid && ack && !redirect && (st_q == StWait);
  assign inst_valid = fifo_valid || bypass;
  assign inst       = bypass ? imem_rdata :
                      (fifo_valid ? inst_mem_q[rd_ptr_q] : 32'h0);
  assign inst_pc    = bypass ? imem_addr :
                      (fifo_valid ? pc_mem_q[rd_ptr_q] : 64'h0);
`else
  assign bypass     = 1'b0;
  assign inst_valid = fifo_valid;
  assign inst       = fifo_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign inst_pc    = fifo_valid ? pc_mem_q[rd_ptr_q] : 64'h0;
`endif

  // A response is kept only in WAIT without redirect, unless the core took it via bypass.
  assign push = (st_q == StWait) && ack && !redirect && !(bypass && inst_ready);

  always_comb begin
    st_d       = st_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    cnt_d      = cnt_q + CntW'(push) - CntW'(fifo_pop);
    if (redirect) begin
      cnt_d = '0;
    end
    unique case (st_q)
      StIdle: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          st_d       = StWait;
        end else if (cnt_d < DepthC) begin
          st_d = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          if (ack) begin
            fetch_pc_d = redirect_pc;
          end else begin
            target_d = redirect_pc;
            st_d     = StDrain;
          end
        end else if (ack) begin
          fetch_pc_d = fetch_pc_q + 64'd4;
          // Issue the next request only if it still has a FIFO slot reserved.
          st_d       = (cnt_d < DepthC) ? StWait : StIdle;
        end
      end
      StDrain: begin
        if (redirect) begin
          target_d = redirect_pc;
        end
        if (ack) begin
          fetch_pc_d = redirect ? redirect_pc : target_q;
          st_d       = StWait;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= StIdle;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      st_q       <= st_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
        if (fifo_pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule
